// File: rtl/dcache_store_buffer_pkg.sv
// Shared types and default parameters for the L1 dcache store buffer.
// The drain FSM encoding lives here so the top and any monitors agree on it.
package dcache_store_buffer_pkg;

  localparam int SB_ADDR_W_DEF = 32;
  localparam int SB_DATA_W_DEF = 32;
  localparam int SB_DEPTH_DEF  = 4;
  localparam int SB_EAGER_DEF  = 1;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } sb_state_e;

endpackage

// File: rtl/dcache_store_buffer_if.sv
// Write port between the store buffer (master) and the L1 dcache (slave).
// Request/address/data/enables are held by the master until the slave acks.
interface dcache_store_buffer_if
  import dcache_store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W_DEF,
  parameter int DATA_W = SB_DATA_W_DEF
);
  localparam int BE_W = DATA_W / 8;

  logic              dc_req;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wr_data;
  logic [BE_W-1:0]   dc_be;
  logic              dc_ack;

  modport master (
    output dc_req, dc_addr, dc_wr_data, dc_be,
    input  dc_ack
  );

  modport slave (
    input  dc_req, dc_addr, dc_wr_data, dc_be,
    output dc_ack
  );

endinterface

// File: rtl/dcache_store_buffer_fwd_merge.sv
// Load-forwarding network: matches valid entries against the load word and
// merges their byte lanes oldest to youngest so the newest store wins.
module dcache_store_buffer_fwd_merge
  import dcache_store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W_DEF,
  parameter int DATA_W = SB_DATA_W_DEF,
  parameter int DEPTH  = SB_DEPTH_DEF,
  localparam int BE_W  = DATA_W / 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic [PTR_W-1:0]             head,
  input  logic [CNT_W-1:0]             count,
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [DEPTH-1:0][BE_W-1:0]   ent_be,
  input  logic                         ld_valid,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [BE_W-1:0]              ld_be,
  output logic                         fwd_hit,
  output logic                         fwd_partial,
  output logic [DATA_W-1:0]            fwd_data
);

  logic [ADDR_W-1:0] ld_word;
  logic [BE_W-1:0]   covered;
  logic [BE_W-1:0]   requested;
  logic [DATA_W-1:0] merged;
  logic [PTR_W-1:0]  idx;

  assign ld_word = ld_addr & ~ADDR_W'(BE_W - 1);

  // Walk from head (oldest) for count entries; later matches overwrite earlier lanes.
  always_comb begin
    covered = '0;
    merged  = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (ent_addr[idx] == ld_word)) begin
        covered = covered | ent_be[idx];
        for (int b = 0; b < BE_W; b++) begin
          if (ent_be[idx][b]) merged[b*8 +: 8] = ent_data[idx][b*8 +: 8];
        end
      end
    end
  end

  assign requested   = covered & ld_be;
  assign fwd_hit     = ld_valid && (requested == ld_be) && (ld_be != '0);
  assign fwd_partial = ld_valid && (requested != '0) && !fwd_hit;

  always_comb begin
    fwd_data = '0;
    if (ld_valid) begin
      for (int b = 0; b < BE_W; b++) begin
        if (ld_be[b]) fwd_data[b*8 +: 8] = merged[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_store_buffer.sv
// Store buffer between MEM and the L1 dcache write port: coalesces same-word
// stores into the youngest entry, drains the head over req/ack, forwards to loads.
module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W_DEF,
  parameter int DATA_W = SB_DATA_W_DEF,
  parameter int DEPTH  = SB_DEPTH_DEF,
  parameter int EAGER  = SB_EAGER_DEF,
  localparam int BE_W  = DATA_W / 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               st_valid,
  input  logic [ADDR_W-1:0]  st_addr,
  input  logic [DATA_W-1:0]  st_data,
  input  logic [BE_W-1:0]    st_be,
  output logic               st_ready,
  input  logic               ld_valid,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [BE_W-1:0]    ld_be,
  output logic               fwd_hit,
  output logic               fwd_partial,
  output logic [DATA_W-1:0]  fwd_data,
  input  logic               drain_all,
  dcache_store_buffer_if.master dc,
  output logic               sb_empty,
  output logic [CNT_W-1:0]   sb_count
);

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(BE_W - 1);
  endfunction

  // Entry payload carries no reset; occupancy is defined purely by head/count.
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [DEPTH-1:0][BE_W-1:0]   ent_be;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] youngest;
  logic [CNT_W-1:0] count;
  sb_state_e        state;
  sb_state_e        state_next;

  logic [ADDR_W-1:0] st_word;
  logic              coalesce_ok;
  logic              enq;
  logic              do_alloc;
  logic              do_coal;
  logic              pop;
  logic              drain_cond;
  logic              req;

  assign st_word  = word_addr(st_addr);
  assign youngest = tail - PTR_W'(1);

  // The head being written to the dcache must not change under the request.
  assign coalesce_ok = (count != '0) && (ent_addr[youngest] == st_word) &&
                       !((state == SB_REQ) && (youngest == head));

  assign st_ready = (count < CNT_W'(DEPTH)) || coalesce_ok;
  assign enq      = st_valid && !stall && !flush && st_ready;
  assign do_coal  = enq && coalesce_ok;
  assign do_alloc = enq && !coalesce_ok;

  assign req = (state == SB_REQ);
  assign pop = req && dc.dc_ack;

  assign drain_cond = (EAGER != 0) || (count >= CNT_W'(DEPTH - 1)) ||
                      drain_all || fwd_partial;

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      ent_addr[tail] <= st_word;
      ent_data[tail] <= st_data;
      ent_be[tail]   <= st_be;
    end else if (do_coal) begin
      for (int b = 0; b < BE_W; b++) begin
        if (st_be[b]) ent_data[youngest][b*8 +: 8] <= st_data[b*8 +: 8];
      end
      ent_be[youngest] <= ent_be[youngest] | st_be;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= SB_IDLE;
    end else begin
      if (pop)      head <= head + PTR_W'(1);
      if (do_alloc) tail <= tail + PTR_W'(1);
      count <= count + CNT_W'(do_alloc) - CNT_W'(pop);
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SB_IDLE: if ((count != '0) && drain_cond) state_next = SB_REQ;
      SB_REQ: begin
        if (dc.dc_ack) begin
          state_next = ((count > CNT_W'(1)) && drain_cond) ? SB_REQ : SB_IDLE;
        end
      end
      default: state_next = SB_IDLE;
    endcase
  end

  assign dc.dc_req     = req;
  assign dc.dc_addr    = req ? ent_addr[head] : '0;
  assign dc.dc_wr_data = req ? ent_data[head] : '0;
  assign dc.dc_be      = req ? ent_be[head]   : '0;

  assign sb_empty = (count == '0);
  assign sb_count = count;

  dcache_store_buffer_fwd_merge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fwd_merge (
    .head        (head),
    .count       (count),
    .ent_addr    (ent_addr),
    .ent_data    (ent_data),
    .ent_be      (ent_be),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_be       (ld_be),
    .fwd_hit     (fwd_hit),
    .fwd_partial (fwd_partial),
    .fwd_data    (fwd_data)
  );

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed, table-driven bench for dcache_store_buffer (DEPTH=4, EAGER=0).
module tb_dcache_store_buffer;

  typedef struct {
    logic        stv;
    logic [31:0] sta;
    logic [31:0] std;
    logic [3:0]  stb;
    logic        ldv;
    logic [31:0] lda;
    logic [3:0]  ldb;
    logic        dra;
    logic        ack;
    logic        stall;
    logic        flush;
  } in_t;

  typedef struct {
    logic        rdy;
    logic        hit;
    logic        part;
    logic [31:0] fdata;
    logic        req;
    logic [31:0] daddr;
    logic [31:0] ddata;
    logic [3:0]  dbe;
    logic        empty;
    logic [2:0]  cnt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_be = '0;
  logic        st_ready;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_be = '0;
  logic        fwd_hit;
  logic        fwd_partial;
  logic [31:0] fwd_data;
  logic        drain_all = 1'b0;
  logic        sb_empty;
  logic [2:0]  sb_count;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  dcache_store_buffer_if #(.ADDR_W(32), .DATA_W(32)) dc_if ();

  dcache_store_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .EAGER(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_be       (st_be),
    .st_ready    (st_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_be       (ld_be),
    .fwd_hit     (fwd_hit),
    .fwd_partial (fwd_partial),
    .fwd_data    (fwd_data),
    .drain_all   (drain_all),
    .dc          (dc_if.master),
    .sb_empty    (sb_empty),
    .sb_count    (sb_count)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(logic stv, logic [31:0] sta, logic [31:0] std, logic [3:0] stb,
                                logic ldv, logic [31:0] lda, logic [3:0] ldb, logic dra, logic ack,
                                logic stl = 1'b0, logic fls = 1'b0);
    in_t r;
    r.stv = stv; r.sta = sta; r.std = std; r.stb = stb;
    r.ldv = ldv; r.lda = lda; r.ldb = ldb; r.dra = dra; r.ack = ack;
    r.stall = stl; r.flush = fls;
    return r;
  endfunction

  function automatic exp_t mk_exp(logic rdy, logic hit, logic part, logic [31:0] fdata, logic req,
                                  logic [31:0] daddr, logic [31:0] ddata, logic [3:0] dbe,
                                  logic empty, logic [2:0] cnt);
    exp_t r;
    r.rdy = rdy; r.hit = hit; r.part = part; r.fdata = fdata; r.req = req;
    r.daddr = daddr; r.ddata = ddata; r.dbe = dbe; r.empty = empty; r.cnt = cnt;
    return r;
  endfunction

  function automatic in_t idle_in();
    return mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t empty_exp();
    return mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(input in_t v);
    st_valid = v.stv; st_addr = v.sta; st_data = v.std; st_be = v.stb;
    ld_valid = v.ldv; ld_addr = v.lda; ld_be = v.ldb;
    drain_all = v.dra; dc_if.dc_ack = v.ack;
    stall = v.stall; flush = v.flush;
  endtask

  task automatic check_row(input string tag, input exp_t e);
    chk({tag, "_ctl"}, 128'({st_ready, dc_if.dc_req, sb_empty, sb_count}),
        128'({e.rdy, e.req, e.empty, e.cnt}));
    chk({tag, "_fwd"}, 128'({fwd_hit, fwd_partial, fwd_data}), 128'({e.hit, e.part, e.fdata}));
    chk({tag, "_bus"}, 128'({dc_if.dc_addr, dc_if.dc_wr_data, dc_if.dc_be}),
        128'({e.daddr, e.ddata, e.dbe}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dc_if.dc_ack = 1'b0;

    // Coalesce two halves of word 0x100 into one entry.
    vecs.push_back('{idle_in(), empty_exp()});
    vecs.push_back('{mk_in(1, 'h100, 'h0000BEEF, 'b0011, 0, 0, 0, 0, 0), empty_exp()});
    vecs.push_back('{mk_in(1, 'h102, 'hCAFE0000, 'b1100, 0, 0, 0, 0, 0), mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 1, 'h100, 'hF, 0, 0), mk_exp(1, 1, 0, 'hCAFEBEEF, 0, 0, 0, 0, 0, 1)});
    // Fill to DEPTH; drain begins once count reaches DEPTH-1.
    vecs.push_back('{mk_in(1, 'h104, 'h11111111, 'hF, 0, 0, 0, 0, 0), mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{mk_in(1, 'h108, 'h22222222, 'hF, 0, 0, 0, 0, 0), mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 2)});
    vecs.push_back('{mk_in(1, 'h10C, 'h33333333, 'hF, 0, 0, 0, 0, 0), mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 3)});
    vecs.push_back('{mk_in(1, 'h200, 'h44444444, 'hF, 0, 0, 0, 0, 0), mk_exp(0, 0, 0, 0, 1, 'h100, 'hCAFEBEEF, 'hF, 0, 4)});
    vecs.push_back('{mk_in(1, 'h10E, 'hAAAA0000, 'hC, 0, 0, 0, 0, 0), mk_exp(1, 0, 0, 0, 1, 'h100, 'hCAFEBEEF, 'hF, 0, 4)});
    vecs.push_back('{mk_in(1, 'h200, 'h44444444, 'hF, 0, 0, 0, 0, 1), mk_exp(0, 0, 0, 0, 1, 'h100, 'hCAFEBEEF, 'hF, 0, 4)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 1, 'h10C, 'hF, 0, 1), mk_exp(1, 1, 0, 'hAAAA3333, 1, 'h104, 'h11111111, 'hF, 0, 3)});
    for (int k = 0; k < 5; k++)
      vecs.push_back('{idle_in(), mk_exp(1, 0, 0, 0, 1, 'h108, 'h22222222, 'hF, 0, 2)});
    vecs.push_back('{mk_in(1, 'h300, 'h55555555, 'hF, 0, 0, 0, 0, 1), mk_exp(1, 0, 0, 0, 1, 'h108, 'h22222222, 'hF, 0, 2)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 1, 'h300, 'h3, 0, 0), mk_exp(1, 1, 0, 'h00005555, 0, 0, 0, 0, 0, 2)});
    // drain_all forces the drain; head wraps from entry 3 to entry 0.
    vecs.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0), mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 2)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1), mk_exp(1, 0, 0, 0, 1, 'h10C, 'hAAAA3333, 'hF, 0, 2)});
    vecs.push_back('{idle_in(), mk_exp(1, 0, 0, 0, 1, 'h300, 'h55555555, 'hF, 0, 1)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1), mk_exp(1, 0, 0, 0, 1, 'h300, 'h55555555, 'hF, 0, 1)});
    vecs.push_back('{idle_in(), empty_exp()});
    // Partial overlap forces a drain even with EAGER=0.
    vecs.push_back('{mk_in(1, 'h100, 'h000000AB, 'h1, 0, 0, 0, 0, 0), empty_exp()});
    vecs.push_back('{mk_in(0, 0, 0, 0, 1, 'h100, 'h3, 0, 0), mk_exp(1, 0, 1, 'h000000AB, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 1, 'h100, 'h3, 0, 0), mk_exp(1, 0, 1, 'h000000AB, 1, 'h100, 'h000000AB, 'h1, 0, 1)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 1, 'h100, 'h3, 0, 1), mk_exp(1, 0, 1, 'h000000AB, 1, 'h100, 'h000000AB, 'h1, 0, 1)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 1, 'h100, 'h3, 0, 0), empty_exp()});
    // stall and flush block enqueue.
    vecs.push_back('{mk_in(1, 'h400, 'h12345678, 'hF, 0, 0, 0, 0, 0, 1, 0), empty_exp()});
    vecs.push_back('{mk_in(1, 'h400, 'h12345678, 'hF, 0, 0, 0, 0, 0, 0, 1), empty_exp()});
    vecs.push_back('{idle_in(), empty_exp()});
    // be=0 store still allocates and drains as a be=0 write; low address bits dropped.
    vecs.push_back('{mk_in(1, 'h503, 'h00000000, 'h0, 0, 0, 0, 0, 0), empty_exp()});
    vecs.push_back('{mk_in(0, 0, 0, 0, 1, 'h500, 'hF, 0, 0), mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0), mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
    vecs.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1), mk_exp(1, 0, 0, 0, 1, 'h500, 'h00000000, 'h0, 0, 1)});
    vecs.push_back('{idle_in(), empty_exp()});

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #1 check_row("reset_hold", empty_exp());
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      apply(vecs[k].i);
      #1 check_row($sformatf("row%0d", k), vecs[k].e);
    end

    // Mid-operation reset with three entries and a live request.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      apply(mk_in(1, 32'h600 + 32'(4 * k), 32'h60 + 32'(k), 'hF, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    apply(idle_in());
    #1 check_row("pre_reset_idle", mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    @(negedge clk);
    #1 check_row("pre_reset_req", mk_exp(1, 0, 0, 0, 1, 'h600, 'h60, 'hF, 0, 3));
    reset = 1'b0;
    #1 check_row("async_reset", empty_exp());
    @(negedge clk);
    #1 check_row("reset_next_cycle", empty_exp());
    reset = 1'b1;
    @(negedge clk);
    #1 check_row("after_reset", empty_exp());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
